// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave AXI-domain control front end.
package spi_slave_pkg;

  localparam int SPI_WRAP_W = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The INIT counter must hold values up to SYNC_STAGES.
  function automatic int init_cnt_w(input int sync_stages);
    return $clog2(sync_stages + 1);
  endfunction

endpackage

// File: rtl/spi_slave_axi_ctrl_sync_if.sv
// SPI-side inputs and AXI-side outputs of the control front end, plus FSM state for observation.
interface spi_slave_axi_ctrl_sync_if #(
  parameter int AXI_ADDR_WIDTH = 32
);
  import spi_slave_pkg::*;

  logic                      spi_cs_async;
  logic [AXI_ADDR_WIDTH-1:0] spi_addr;
  logic                      spi_addr_tgl_async;
  logic                      spi_rd_tgl_async;
  logic [SPI_WRAP_W-1:0]     spi_wrap;
  logic                      spi_wrap_tgl_async;

  // rxtx_addr_valid and start_tx are single-cycle pulses; the consumer has no ready and
  // must take them in the cycle they are high. rxtx_addr/wrap_length hold until the next capture.
  logic                      cs;
  logic [AXI_ADDR_WIDTH-1:0] rxtx_addr;
  logic                      rxtx_addr_valid;
  logic                      start_tx;
  logic [SPI_WRAP_W-1:0]     wrap_length;
  logic                      addr_ack_tgl;
  logic                      wrap_ack_tgl;
  logic                      start_dropped;
  state_e                    dbg_state;

  modport slave (
    input  spi_cs_async, spi_addr, spi_addr_tgl_async, spi_rd_tgl_async,
           spi_wrap, spi_wrap_tgl_async,
    output cs, rxtx_addr, rxtx_addr_valid, start_tx, wrap_length,
           addr_ack_tgl, wrap_ack_tgl, start_dropped, dbg_state
  );

  modport master (
    output spi_cs_async, spi_addr, spi_addr_tgl_async, spi_rd_tgl_async,
           spi_wrap, spi_wrap_tgl_async,
    input  cs, rxtx_addr, rxtx_addr_valid, start_tx, wrap_length,
           addr_ack_tgl, wrap_ack_tgl, start_dropped, dbg_state
  );

endinterface

// File: rtl/spi_slave_tgl_sync.sv
// Multi-stage synchroniser with a reference register; event_o is high while the
// synchronised level differs from the last level accepted.
module spi_slave_tgl_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  input  logic init_i,
  output logic level_o,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ref_q;
  logic                   ref_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      ref_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      ref_q  <= ref_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign event_o = level_o != ref_q;

  always_comb begin
    ref_d = ref_q;
    if (init_i || event_o) ref_d = level_o;
  end

endmodule

// File: rtl/spi_slave_axi_ctrl_sync.sv
// AXI-domain control front end: synchronises SPI toggle events into pulses and held
// captures, and returns acknowledge toggles for the multi-bit buses.
module spi_slave_axi_ctrl_sync
  import spi_slave_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  spi_slave_axi_ctrl_sync_if.slave bus
);

  localparam int               CNT_W    = init_cnt_w(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SPI_WRAP_W-1:0]     wrap_q, wrap_d;
  logic                      valid_q, valid_d;
  logic                      start_q, start_d;
  logic                      aack_q, aack_d;
  logic                      wack_q, wack_d;
  logic                      drop_q, drop_d;

  logic in_init;
  logic cs_lvl, cs_event_unused;
  logic addr_lvl, addr_evt;
  logic rd_lvl_unused, rd_evt;
  logic wrap_lvl, wrap_evt;

  assign in_init = (state_q == INIT);

  spi_slave_tgl_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i(axi_aclk), .rst_ni(axi_aresetn), .async_i(bus.spi_cs_async),
    .init_i(in_init), .level_o(cs_lvl), .event_o(cs_event_unused)
  );

  spi_slave_tgl_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_addr_sync (
    .clk_i(axi_aclk), .rst_ni(axi_aresetn), .async_i(bus.spi_addr_tgl_async),
    .init_i(in_init), .level_o(addr_lvl), .event_o(addr_evt)
  );

  spi_slave_tgl_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_rd_sync (
    .clk_i(axi_aclk), .rst_ni(axi_aresetn), .async_i(bus.spi_rd_tgl_async),
    .init_i(in_init), .level_o(rd_lvl_unused), .event_o(rd_evt)
  );

  spi_slave_tgl_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_wrap_sync (
    .clk_i(axi_aclk), .rst_ni(axi_aresetn), .async_i(bus.spi_wrap_tgl_async),
    .init_i(in_init), .level_o(wrap_lvl), .event_o(wrap_evt)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= INIT;
      cnt_q   <= '0;
      addr_q  <= '0;
      wrap_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      aack_q  <= 1'b0;
      wack_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      start_q <= start_d;
      aack_q  <= aack_d;
      wack_q  <= wack_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wrap_d  = wrap_q;
    valid_d = 1'b0;
    start_d = 1'b0;
    aack_d  = aack_q;
    wack_d  = wack_q;
    drop_d  = drop_q;
    if (state_q == INIT) begin
      // Acks track whatever level the SPI side left behind so no handshake starts out of step.
      aack_d = addr_lvl;
      wack_d = wrap_lvl;
      if (cnt_q == CNT_LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (addr_evt) begin
        addr_d  = bus.spi_addr;
        valid_d = 1'b1;
        aack_d  = ~aack_q;
        drop_d  = 1'b0;
      end
      if (wrap_evt) begin
        wrap_d = bus.spi_wrap;
        wack_d = ~wack_q;
      end
      // Evaluated after the address clear so a same-cycle drop still sets the flag.
      if (rd_evt) begin
        if (!cs_lvl) start_d = 1'b1;
        else         drop_d  = 1'b1;
      end
    end
  end

  assign bus.cs              = cs_lvl;
  assign bus.rxtx_addr       = addr_q;
  assign bus.rxtx_addr_valid = valid_q;
  assign bus.start_tx        = start_q;
  assign bus.wrap_length     = wrap_q;
  assign bus.addr_ack_tgl    = aack_q;
  assign bus.wrap_ack_tgl    = wack_q;
  assign bus.start_dropped   = drop_q;
  assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_spi_slave_axi_ctrl_sync.sv
// Bench for spi_slave_axi_ctrl_sync: directed scenarios plus random event traffic
// compared every cycle against a latency-based model.
module tb_spi_slave_axi_ctrl_sync;
  import spi_slave_pkg::*;

  localparam int AW = 32;
  localparam int S  = 2;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  spi_slave_axi_ctrl_sync_if #(.AXI_ADDR_WIDTH(AW)) bus ();

  spi_slave_axi_ctrl_sync #(.AXI_ADDR_WIDTH(AW), .SYNC_STAGES(S)) dut (
    .axi_aclk   (clk),
    .axi_aresetn(rstn),
    .bus        (bus.slave)
  );

  // ---------------- model state ----------------
  // An input change driven just after edge c is first sampled at edge c+1; events
  // appear at edge c+1+S, cs follows at edge c+S.
  logic [AW-1:0] exp_q[$];
  bit            ev_addr[int];
  bit            ev_rd[int];
  logic [15:0]   ev_wrap[int];
  bit            ev_cs[int];
  bit            m_cs, m_aack, m_wack, m_drop, ack_chk, run_cmp;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_wrap;
  bit            exp_v, exp_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ev_addr.delete();
    ev_rd.delete();
    ev_wrap.delete();
    ev_cs.delete();
    exp_q.delete();
    m_cs    = 1'b1;
    m_addr  = '0;
    m_wrap  = '0;
    m_aack  = 1'b0;
    m_wack  = 1'b0;
    m_drop  = 1'b0;
    ack_chk = 1'b0;
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (run_cmp) begin
      if (!rstn) begin
        chk("rst_cs",    64'(bus.cs), 64'd1);
        chk("rst_addr",  64'(bus.rxtx_addr), 64'd0);
        chk("rst_valid", 64'(bus.rxtx_addr_valid), 64'd0);
        chk("rst_start", 64'(bus.start_tx), 64'd0);
        chk("rst_wrap",  64'(bus.wrap_length), 64'd0);
        chk("rst_aack",  64'(bus.addr_ack_tgl), 64'd0);
        chk("rst_wack",  64'(bus.wrap_ack_tgl), 64'd0);
        chk("rst_drop",  64'(bus.start_dropped), 64'd0);
        chk("rst_state", 64'(bus.dbg_state), 64'(INIT));
      end else begin
        exp_v = 1'b0;
        exp_s = 1'b0;
        if (ev_addr.exists(cyc)) begin
          exp_v  = 1'b1;
          m_addr = (exp_q.size() != 0) ? exp_q.pop_front() : m_addr;
          m_aack = ~m_aack;
          m_drop = 1'b0;
        end
        if (ev_rd.exists(cyc)) begin
          if (!m_cs) exp_s  = 1'b1;
          else       m_drop = 1'b1;
        end
        if (ev_wrap.exists(cyc)) begin
          m_wrap = ev_wrap[cyc];
          m_wack = ~m_wack;
        end
        if (ev_cs.exists(cyc)) m_cs = ev_cs[cyc];
        if (cyc == S + 1) begin
          m_aack  = bus.spi_addr_tgl_async;
          m_wack  = bus.spi_wrap_tgl_async;
          ack_chk = 1'b1;
        end
        chk("valid", 64'(bus.rxtx_addr_valid), 64'(exp_v));
        chk("start", 64'(bus.start_tx), 64'(exp_s));
        chk("addr",  64'(bus.rxtx_addr), 64'(m_addr));
        chk("wrap",  64'(bus.wrap_length), 64'(m_wrap));
        chk("cs",    64'(bus.cs), 64'(m_cs));
        chk("drop",  64'(bus.start_dropped), 64'(m_drop));
        chk("state", 64'(bus.dbg_state), (cyc <= S) ? 64'(INIT) : 64'(RUN));
        if (ack_chk) begin
          chk("aack", 64'(bus.addr_ack_tgl), 64'(m_aack));
          chk("wack", 64'(bus.wrap_ack_tgl), 64'(m_wack));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int t);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (cyc >= t) break;
      n++;
      if (n > 500) begin
        chk("wait_timeout", 64'(cyc), 64'(t));
        break;
      end
    end
  endtask

  task automatic drv_addr(input logic [AW-1:0] a, input bit with_rd);
    int e;
    e = cyc + 1 + S;
    bus.spi_addr           = a;
    bus.spi_addr_tgl_async = ~bus.spi_addr_tgl_async;
    ev_addr[e]             = 1'b1;
    exp_q.push_back(a);
    if (with_rd) begin
      bus.spi_rd_tgl_async = ~bus.spi_rd_tgl_async;
      ev_rd[e]             = 1'b1;
    end
  endtask

  task automatic drv_rd();
    bus.spi_rd_tgl_async = ~bus.spi_rd_tgl_async;
    ev_rd[cyc + 1 + S]   = 1'b1;
  endtask

  task automatic drv_wrap(input logic [15:0] w);
    bus.spi_wrap           = w;
    bus.spi_wrap_tgl_async = ~bus.spi_wrap_tgl_async;
    ev_wrap[cyc + 1 + S]   = w;
  endtask

  task automatic drv_cs(input bit v);
    if (bus.spi_cs_async != v) begin
      bus.spi_cs_async = v;
      ev_cs[cyc + S]   = v;
    end
  endtask

  task automatic assert_reset();
    rstn = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    if (!bus.spi_cs_async) ev_cs[S] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int op;
    run_cmp                = 1'b0;
    model_reset();
    bus.spi_cs_async       = 1'b1;
    bus.spi_addr           = '0;
    bus.spi_wrap           = '0;
    bus.spi_addr_tgl_async = 1'b1;
    bus.spi_rd_tgl_async   = 1'b1;
    bus.spi_wrap_tgl_async = 1'b1;
    run_cmp                = 1'b1;
    repeat (3) @(posedge clk);
    release_reset();

    // toggles held high through INIT: acks follow, no pulses
    wait_neg(S + 2);
    chk("init_aack", 64'(bus.addr_ack_tgl), 64'd1);
    chk("init_wack", 64'(bus.wrap_ack_tgl), 64'd1);
    chk("init_nostart", 64'(bus.start_tx), 64'd0);
    step(1);

    c = cyc;
    drv_addr(32'h1C00_0040, 1'b0);
    wait_neg(c + S);
    chk("addr_early", 64'(bus.rxtx_addr_valid), 64'd0);
    wait_neg(c + S + 1);
    chk("addr_pulse", 64'(bus.rxtx_addr_valid), 64'd1);
    chk("addr_val",   64'(bus.rxtx_addr), 64'h1C00_0040);
    chk("addr_ack",   64'(bus.addr_ack_tgl), 64'd0);
    wait_neg(c + S + 2);
    chk("addr_pulse_end", 64'(bus.rxtx_addr_valid), 64'd0);
    chk("addr_held",      64'(bus.rxtx_addr), 64'h1C00_0040);
    step(1);

    drv_cs(1'b0);
    step(S + 2);
    c = cyc;
    drv_addr(32'h2000_0100, 1'b1);
    wait_neg(c + S + 1);
    chk("both_valid", 64'(bus.rxtx_addr_valid), 64'd1);
    chk("both_start", 64'(bus.start_tx), 64'd1);
    chk("both_addr",  64'(bus.rxtx_addr), 64'h2000_0100);
    step(S + 2);

    drv_cs(1'b1);
    step(S + 2);
    c = cyc;
    drv_rd();
    wait_neg(c + S + 1);
    chk("drop_start", 64'(bus.start_tx), 64'd0);
    chk("drop_set",   64'(bus.start_dropped), 64'd1);
    step(1);
    c = cyc;
    drv_addr(32'h3000_0000, 1'b0);
    wait_neg(c + S + 1);
    chk("drop_clear", 64'(bus.start_dropped), 64'd0);
    step(S + 2);

    c = cyc;
    drv_wrap(16'h0010);
    wait_neg(c + S + 1);
    chk("wrap_val",   64'(bus.wrap_length), 64'h0010);
    chk("wrap_nov",   64'(bus.rxtx_addr_valid), 64'd0);
    chk("wrap_nost",  64'(bus.start_tx), 64'd0);
    step(S + 2);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0:       drv_addr($urandom, 1'b0);
        1:       drv_rd();
        2:       drv_wrap(16'($urandom));
        3:       drv_addr($urandom, 1'b1);
        default: drv_cs(~bus.spi_cs_async);
      endcase
      step($urandom_range(S + 1, S + 5));
    end
    step(S + 4);

    // reset lands while an address event is still in the synchroniser
    c = cyc;
    drv_addr(32'hDEAD_BEEF, 1'b0);
    step(1);
    assert_reset();
    step(2);
    release_reset();
    wait_neg(S);
    chk("reinit_state", 64'(bus.dbg_state), 64'(INIT));
    wait_neg(S + 1);
    chk("reinit_run", 64'(bus.dbg_state), 64'(RUN));
    chk("reinit_addr", 64'(bus.rxtx_addr), 64'd0);
    step(S + 6);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
